aig_vector_sweeper: RTL
=======================

Name: aig_vector_sweeper

Overview:
- Sequencer that exhaustively drives a small combinational AIG netlist (N_IN inputs, N_OUT outputs) through all 2^N_IN input vectors.
- After a programmable settle time it captures each response, streams (vector, response) pairs over a valid/ready port, and folds every response into a running MISR signature.
- Sits beside each generated benchmark netlist in the dataset test harness and produces truth tables and signatures for equivalence checks between the original and balanced variants.

Parameters:
- N_IN, 3, number of netlist primary inputs (1..16).
- N_OUT, 13, number of netlist primary outputs (2..64).
- SETTLE, 1, clock cycles between applying a vector and sampling the outputs (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  cancel the sweep; highest priority after rst.
- x_o  output  N_IN  vector driven to the netlist inputs.
- f_i  input  N_OUT  netlist outputs.
- res_valid  output  1  a result pair is available.
- res_ready  input  1  consumer accepts the result.
- res_vec  output  N_IN  vector of the current result.
- res_out  output  N_OUT  captured response.
- sig_o  output  N_OUT  MISR signature.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset (async, active-high) values: state=IDLE; x_o, res_vec, res_out, sig_o = 0; res_valid, busy, done = 0.
- States: IDLE, APPLY, CAPTURE, EMIT, FIN.
- IDLE: on start, set vec=0, x_o=0, sig_o=0, load the settle counter with SETTLE-1, go to APPLY.
- APPLY: x_o holds vec. The counter decrements each cycle. When it reaches 0, go to CAPTURE. x_o is therefore stable for exactly SETTLE cycles before sampling.
- CAPTURE: one cycle. On this edge: res_out<=f_i; res_vec<=vec; sig_o<={sig_o[N_OUT-2:0],sig_o[N_OUT-1]} ^ f_i; res_valid<=1; go to EMIT.
- EMIT: res_valid, res_vec and res_out are held stable until res_valid & res_ready.
  - On the handshake edge: res_valid<=0.
  - If vec == all-ones, go to FIN.
  - Otherwise vec<=vec+1, x_o<=vec+1, reload the counter, go to APPLY.
- Vector counter: the last vector is detected by compare, so vec never wraps.
- FIN: done=1 for exactly one cycle, then IDLE. sig_o and the last res_* values are held until the next start.
- start while busy: ignored.
- abort (any non-IDLE state): next edge goes to IDLE, res_valid=0, no done pulse. sig_o and x_o keep their last values.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- Throughput, with res_ready tied high: SETTLE+2 cycles per vector. A full sweep takes 2^N_IN*(SETTLE+2)+1 cycles from start to done.
- busy is a registered function of state; done is a registered pulse.
- f_i is sampled only in CAPTURE. Glitches at other times have no effect.

Decomposition:
- Shared package aig_sweep_pkg holds:
  - the state enum (IDLE, APPLY, CAPTURE, EMIT, FIN);
  - a misr_step function (rotate-left-by-1 XOR data, parameterised width);
  - the SETTLE_MIN=1 constant.
- One natural sub-module, aig_misr: signature register with clear/enable, reusable by the comparison harness.
- The FSM, vector counter and settle counter stay in the top module.

Test Plan:
- Basic sweep: N_IN=2, N_OUT=4, SETTLE=1, loopback f_i={2'b00,x_o}, res_ready=1, start pulse -> results (0,0000),(1,0001),(2,0010),(3,0011); sig_o=4'b0011; done pulses 13 cycles after start.
- Backpressure: same setup, res_ready low for 5 cycles on vector 1 -> res_valid/res_vec=1/res_out=0001 held stable for all 5 cycles, no vector skipped, final sig_o=4'b0011.
- Settle timing: SETTLE=3, f_i driven by a model that updates 2 cycles after x_o changes -> every captured res_out matches the settled value; x_o stable for 3 cycles before each capture.
- Abort: assert abort during APPLY of vector 2 -> IDLE next cycle, busy=0, no done pulse, res_valid=0. A new start restarts at vector 0 with sig_o cleared.
- Async reset mid-EMIT: pulse rst between clock edges -> all outputs 0 immediately without a clock edge, state IDLE.
- start while busy, and start+abort together in IDLE -> no restart, no state change.

Source files
------------

// File: rtl/aig_sweep_pkg.sv
// aig_sweep_pkg: shared state encoding, MISR step and constants for the vector sweeper
package aig_sweep_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, CAPTURE, EMIT, FIN} state_t;
  localparam int SETTLE_MIN = 1;
  // rotate the low w bits of s left by one and xor in d; operands are zero-extended to 64 bits
  function automatic logic [63:0] misr_step(input logic [63:0] s, input logic [63:0] d, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (i < w) r[i] = (i == 0 ? s[w-1] : s[i-1]) ^ d[i];
    return r;
  endfunction
endpackage

// File: rtl/aig_misr.sv
// aig_misr: multiple-input signature register with synchronous clear and enable
module aig_misr
  import aig_sweep_pkg::*;
#(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sig
);
  // clear wins over fold so a new sweep always starts from zero
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= '0;
    else if (clr) sig <= '0;
    else if (en) sig <= W'(misr_step(64'(sig), 64'(d), W));
endmodule

// File: rtl/aig_vector_sweeper.sv
// aig_vector_sweeper: walks a combinational netlist through every input vector, streams responses and signs them
module aig_vector_sweeper
  import aig_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 13,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  x_o,
  input  logic [N_OUT-1:0] f_i,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_IN-1:0]  res_vec,
  output logic [N_OUT-1:0] res_out,
  output logic [N_OUT-1:0] sig_o,
  output logic             busy,
  output logic             done
);
  localparam logic [15:0] RELOAD = 16'((SETTLE < SETTLE_MIN ? SETTLE_MIN : SETTLE) - 1);
  state_t      state;
  logic [15:0] cnt;
  logic        clear, capture;
  assign clear   = state == IDLE && start && !abort;
  assign capture = state == CAPTURE && !abort;
  aig_misr #(.W(N_OUT)) u_misr (
    .clk(clk),
    .rst(rst),
    .clr(clear),
    .en (capture),
    .d  (f_i),
    .sig(sig_o)
  );
  // sweep sequencer; x_o doubles as the vector counter since it always holds the current vector
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      x_o       <= '0;
      res_vec   <= '0;
      res_out   <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        res_valid <= 1'b0;
        busy      <= 1'b0;
      end else
        case (state)
          IDLE:
            if (start) begin
              x_o   <= '0;
              cnt   <= RELOAD;
              state <= APPLY;
              busy  <= 1'b1;
            end
          APPLY:
            if (cnt == 16'd0) state <= CAPTURE;
            else cnt <= cnt - 16'd1;
          CAPTURE: begin
            res_out   <= f_i;
            res_vec   <= x_o;
            res_valid <= 1'b1;
            state     <= EMIT;
          end
          EMIT:
            if (res_ready) begin
              res_valid <= 1'b0;
              if (&x_o) state <= FIN;
              else begin
                x_o   <= x_o + 1'b1;
                cnt   <= RELOAD;
                state <= APPLY;
              end
            end
          FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
    end
endmodule
